bit_serializer: RTL and testbench

//  Parallel-to-serial stage feeding the 1011 sequence detector's x input, one bit per clk.

---
 rtl/bit_serializer.sv | 168 ++++++++++++++++
 tb/tb_bit_serializer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a one-word holding buffer and a valid/ready intake.
// Words go out on x one bit per clk, MSB- or LSB-first, with optional idle gaps.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned    CW        = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LOAD  = CW'(WIDTH - 1);
    localparam logic [7:0]     GCNT_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hbuf;
    logic             r_hfull;
    logic             w_hfull_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [7:0]       r_gcnt;
    logic [7:0]       w_gcnt_nxt;
    logic             r_x;
    logic             w_x_nxt;
    logic             r_x_valid;
    logic             w_x_valid_nxt;
    logic             r_word_done;
    logic             w_word_done_nxt;
    logic             w_accept;
    logic             w_load;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_hbuf_shifted;
    logic [WIDTH-1:0] w_sreg_shifted;

    // sreg always holds the not-yet-sent bits aligned so the next bit sits at the send end
    assign w_first_bit    = MSB_FIRST ? r_hbuf[WIDTH-1] : r_hbuf[0];
    assign w_next_bit     = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];
    assign w_hbuf_shifted = MSB_FIRST ? (r_hbuf << 1) : (r_hbuf >> 1);
    assign w_sreg_shifted = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);

    assign w_accept = din_valid & ~r_hfull;

    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_cnt_nxt       = r_cnt;
        w_gcnt_nxt      = r_gcnt;
        w_x_nxt         = r_x;
        w_x_valid_nxt   = r_x_valid;
        w_word_done_nxt = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_hfull) begin
                    w_load = 1'b1;
                end else begin
                    w_x_nxt       = IDLE_BIT;
                    w_x_valid_nxt = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (r_cnt != '0) begin
                    w_x_nxt         = w_next_bit;
                    w_sreg_nxt      = w_sreg_shifted;
                    w_cnt_nxt       = r_cnt - CW'(1);
                    w_word_done_nxt = (r_cnt == CW'(1));
                end else if (GAP > 0) begin
                    w_x_nxt       = IDLE_BIT;
                    w_x_valid_nxt = 1'b0;
                    w_gcnt_nxt    = GCNT_LOAD;
                    w_state_nxt   = ST_GAP;
                end else if (r_hfull) begin
                    w_load = 1'b1;
                end else begin
                    w_x_nxt       = IDLE_BIT;
                    w_x_valid_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (r_gcnt != 8'd0) begin
                    w_gcnt_nxt = r_gcnt - 8'd1;
                end else if (r_hfull) begin
                    w_load = 1'b1;
                end else begin
                    w_x_nxt       = IDLE_BIT;
                    w_x_valid_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_x_nxt       = IDLE_BIT;
                w_x_valid_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_sreg_nxt    = w_hbuf_shifted;
            w_x_nxt       = w_first_bit;
            w_x_valid_nxt = 1'b1;
            w_cnt_nxt     = CNT_LOAD;
            w_state_nxt   = ST_SHIFT;
        end

        // accept needs an empty buffer, so it never collides with a load
        if (w_load) begin
            w_hfull_nxt = 1'b0;
        end else if (w_accept) begin
            w_hfull_nxt = 1'b1;
        end else begin
            w_hfull_nxt = r_hfull;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= ST_IDLE;
            r_hbuf      <= '0;
            r_hfull     <= 1'b0;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_gcnt      <= 8'd0;
            r_x         <= IDLE_BIT;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hfull     <= w_hfull_nxt;
            r_sreg      <= w_sreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_x         <= w_x_nxt;
            r_x_valid   <= w_x_valid_nxt;
            r_word_done <= w_word_done_nxt;
            if (w_accept) begin
                r_hbuf <= din;
            end
        end
    end

    assign din_ready = ~r_hfull;
    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign word_done = r_word_done;
    assign busy      = (r_state != ST_IDLE) | r_hfull;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default MSB-first, LSB-first and GAP=2 instances
// share the clock and reset; expected bit streams are written out by hand.
module tb_bit_serializer;

    logic clk;
    logic clr_n;

    logic [7:0] a_din, b_din, c_din;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_x, b_x, c_x;
    logic       a_xv, b_xv, c_xv;
    logic       a_wd, b_wd, c_wd;
    logic       a_busy, b_busy, c_busy;

    int n_checks;
    int n_fail;

    bit_serializer u_a (
        .clk(clk), .clr_n(clr_n), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
        .x(a_x), .x_valid(a_xv), .word_done(a_wd), .busy(a_busy)
    );

    bit_serializer #(.MSB_FIRST(1'b0)) u_b (
        .clk(clk), .clr_n(clr_n), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
        .x(b_x), .x_valid(b_xv), .word_done(b_wd), .busy(b_busy)
    );

    bit_serializer #(.GAP(2)) u_c (
        .clk(clk), .clr_n(clr_n), .din(c_din), .din_valid(c_valid), .din_ready(c_ready),
        .x(c_x), .x_valid(c_xv), .word_done(c_wd), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0]  w1;
        logic [15:0] s2;
        logic [23:0] s3;
        logic [7:0]  w4a, w4b;
        logic        ev;
        logic        ex;

        n_checks = 0;
        n_fail   = 0;
        clr_n    = 1'b0;
        a_din = 8'h00; b_din = 8'h00; c_din = 8'h00;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

        // reset state
        tick();
        chk("rst_x", a_x, 0);
        chk("rst_xv", a_xv, 0);
        chk("rst_wd", a_wd, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_c_busy", c_busy, 0);
        #2 clr_n = 1'b1;
        tick();
        tick();

        // T1: single MSB-first word
        w1 = 8'b1011_0000;
        a_din = w1; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("t1_ready_after_accept", a_ready, 0);
        chk("t1_xv_before_first", a_xv, 0);
        chk("t1_busy_after_accept", a_busy, 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t1_x", a_x, w1[7-i]);
            chk("t1_xv", a_xv, 1);
            chk("t1_wd", a_wd, 32'(i == 7));
        end
        tick();
        chk("t1_idle_x", a_x, 0);
        chk("t1_idle_xv", a_xv, 0);
        chk("t1_idle_wd", a_wd, 0);
        chk("t1_idle_busy", a_busy, 0);
        chk("t1_idle_ready", a_ready, 1);
        tick();

        // T2: back-to-back words, no bubble
        s2 = 16'hB65A;
        a_din = 8'hB6; a_valid = 1'b1;
        tick();
        chk("t2_ready_first_accept", a_ready, 0);
        a_din = 8'h5A;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 1) a_valid = 1'b0;
            chk("t2_x", a_x, s2[15-k]);
            chk("t2_xv", a_xv, 1);
            chk("t2_wd", a_wd, 32'(k == 7 || k == 15));
            chk("t2_ready", a_ready, 32'(k == 0 || k >= 8));
        end
        tick();
        chk("t2_idle_xv", a_xv, 0);
        chk("t2_idle_x", a_x, 0);
        chk("t2_idle_busy", a_busy, 0);
        tick();

        // T6: din_valid held high through stalls; three words each sent exactly once
        s3 = 24'hC3813C;
        a_din = 8'hC3; a_valid = 1'b1;
        tick();
        a_din = 8'h81;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (k == 1) a_din = 8'h3C;
            if (k == 9) a_valid = 1'b0;
            chk("t6_x", a_x, s3[23-k]);
            chk("t6_xv", a_xv, 1);
            chk("t6_wd", a_wd, 32'(k == 7 || k == 15 || k == 23));
            chk("t6_ready", a_ready, 32'(k == 0 || k == 8 || k >= 16));
        end
        tick();
        chk("t6_no_dup_xv", a_xv, 0);
        chk("t6_no_dup_busy", a_busy, 0);
        tick();
        chk("t6_no_dup_xv2", a_xv, 0);

        // T3: LSB-first instance
        w1 = 8'b0000_1101;
        b_din = w1; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        chk("t3_xv_before_first", b_xv, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t3_x", b_x, w1[i]);
            chk("t3_xv", b_xv, 1);
            chk("t3_wd", b_wd, 32'(i == 7));
        end
        tick();
        chk("t3_idle_xv", b_xv, 0);
        chk("t3_idle_busy", b_busy, 0);

        // T4: GAP=2 instance, two buffered words
        w4a = 8'hA5;
        w4b = 8'h3C;
        c_din = w4a; c_valid = 1'b1;
        tick();
        c_din = w4b;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (k == 1) c_valid = 1'b0;
            ev = (k < 8) || (k >= 10);
            if (k < 8)       ex = w4a[7-k];
            else if (k < 10) ex = 1'b0;
            else             ex = w4b[17-k];
            chk("t4_x", c_x, ex);
            chk("t4_xv", c_xv, ev);
            chk("t4_wd", c_wd, 32'(k == 7 || k == 17));
            chk("t4_busy", c_busy, 1);
        end
        tick();
        chk("t4_tail_gap_xv", c_xv, 0);
        chk("t4_tail_gap_busy", c_busy, 1);
        tick();
        chk("t4_tail_gap2_busy", c_busy, 1);
        tick();
        chk("t4_idle_busy", c_busy, 0);
        chk("t4_idle_ready", c_ready, 1);

        // T5: reset mid-word with a second word buffered
        a_din = 8'hFF; a_valid = 1'b1;
        tick();
        tick();
        tick();
        a_valid = 1'b0;
        tick();
        chk("t5_bit3_x", a_x, 1);
        chk("t5_bit3_ready", a_ready, 0);
        #2 clr_n = 1'b0;
        #1;
        chk("t5_rst_x", a_x, 0);
        chk("t5_rst_xv", a_xv, 0);
        chk("t5_rst_ready", a_ready, 1);
        chk("t5_rst_busy", a_busy, 0);
        #2 clr_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t5_after_xv", a_xv, 0);
            chk("t5_after_x", a_x, 0);
        end
        chk("t5_after_busy", a_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
